gcd_ctrl: RTL and testbench

Sequencer for the Euclidean GCD datapath. It accepts an operand pair, then repeatedly drives an external `modulo_u` instance (start / dividend / divisor → done / remainder) until the remainder is zero, and returns the GCD. It sits between the bus-facing register block and the modulo unit, and is the only master of the modulo unit's inputs.

---
 rtl/gcd_ctrl.sv | 118 +++++++++++
 tb/tb_gcd_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gcd_ctrl.sv
// Euclidean GCD sequencer: drives an external modulo unit until the remainder is zero.
// Optional iteration-count output port `iters` is enabled by defining GCD_ITER_COUNT_EN.
module gcd_ctrl #(
  parameter int WIDTH    = 64,
  parameter int MAX_ITER = 96,
  localparam int CW      = $clog2(MAX_ITER + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd,
  output logic             err,
  output logic             mod_start,
  output logic [WIDTH-1:0] mod_dividend,
  output logic [WIDTH-1:0] mod_divisor,
  input  logic             mod_done,
  input  logic [WIDTH-1:0] mod_remainder
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [CW-1:0]    iters
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] y_reg;
  logic [CW-1:0]    cnt_reg;

  logic rem_zero;
  logic limit_hit;
  assign rem_zero  = (mod_remainder == '0);
  assign limit_hit = (cnt_reg == CW'(MAX_ITER));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      x_reg        <= '0;
      y_reg        <= '0;
      cnt_reg      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      gcd          <= '0;
      mod_start    <= 1'b0;
      mod_dividend <= '0;
      mod_divisor  <= '0;
    end else begin
      done      <= 1'b0;
      mod_start <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            x_reg   <= a;
            y_reg   <= b;
            cnt_reg <= '0;
            err     <= 1'b0;
            // Zero checks on the raw inputs make a=b=0 report gcd=0.
            if (b == '0) begin
              gcd  <= a;
              done <= 1'b1;
            end else if (a == '0) begin
              gcd  <= b;
              done <= 1'b1;
            end else begin
              busy      <= 1'b1;
              state_reg <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mod_dividend <= x_reg;
          mod_divisor  <= y_reg;
          mod_start    <= 1'b1;
          cnt_reg      <= cnt_reg + CW'(1);
          state_reg    <= WAIT;
        end
        WAIT: begin
          if (mod_done) begin
            if (rem_zero || limit_hit) begin
              gcd       <= y_reg;
              err       <= ~rem_zero;
              done      <= 1'b1;
              busy      <= 1'b0;
              state_reg <= IDLE;
            end else begin
              x_reg     <= y_reg;
              y_reg     <= mod_remainder;
              state_reg <= ISSUE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef GCD_ITER_COUNT_EN
  // Snapshot of operations issued, taken whenever done fires (0 on early exit).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iters <= '0;
    end else if (state_reg == IDLE && start && (a == '0 || b == '0)) begin
      iters <= '0;
    end else if (state_reg == WAIT && mod_done && (rem_zero || limit_hit)) begin
      iters <= cnt_reg;
    end
  end
`endif

endmodule

// File: tb/tb_gcd_ctrl.sv
// Scoreboard bench for gcd_ctrl with a behavioural modulo unit (fixed latency).
module tb_gcd_ctrl;
  localparam int W   = 16;
  localparam int MI  = 4;
  localparam int CW  = $clog2(MI + 1);
  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, err, mod_start, mod_done;
  logic [W-1:0] gcd, mod_dividend, mod_divisor, mod_remainder;
`ifdef GCD_ITER_COUNT_EN
  logic [CW-1:0] iters;
`endif

  gcd_ctrl #(.WIDTH(W), .MAX_ITER(MI)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .gcd(gcd), .err(err),
    .mod_start(mod_start), .mod_dividend(mod_dividend), .mod_divisor(mod_divisor),
    .mod_done(mod_done), .mod_remainder(mod_remainder)
`ifdef GCD_ITER_COUNT_EN
    , .iters(iters)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural modulo unit sharing rst
  int           mcnt;
  logic [W-1:0] m_dvd, m_dvs;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt <= 0; mod_done <= 1'b0; mod_remainder <= '0; m_dvd <= '0; m_dvs <= '0;
    end else begin
      mod_done <= 1'b0;
      if (mod_start) begin
        mcnt <= LAT; m_dvd <= mod_dividend; m_dvs <= mod_divisor;
      end else if (mcnt > 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) begin
          mod_done      <= 1'b1;
          mod_remainder <= m_dvd % m_dvs;
        end
      end
    end
  end

  typedef struct { logic [W-1:0] g; logic e; int it; } res_t;
  res_t         exp_res[$];
  logic [2*W-1:0] exp_op[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push_op(input int dvd, input int dvs);
    exp_op.push_back({W'(dvd), W'(dvs)});
  endtask

  task automatic push_res(input int g, input logic e, input int it);
    res_t r;
    r.g = W'(g); r.e = e; r.it = it;
    exp_res.push_back(r);
  endtask

  // Monitor: pops expectations whenever the DUT presents mod_start or done
  always @(negedge clk) begin
    if (!rst && mod_start) begin
      if (exp_op.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL mod_op_unexpected: got %0d/%0d expected none", mod_dividend, mod_divisor);
      end else begin
        logic [2*W-1:0] o;
        o = exp_op.pop_front();
        $display("mod op %0d %% %0d", mod_dividend, mod_divisor);
        check("mod_dividend", 64'(mod_dividend), 64'(o[2*W-1:W]));
        check("mod_divisor", 64'(mod_divisor), 64'(o[W-1:0]));
      end
    end
    if (!rst && done) begin
      if (exp_res.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL done_unexpected: got gcd=%0d expected no done", gcd);
      end else begin
        res_t r;
        r = exp_res.pop_front();
        $display("job done gcd=%0d err=%0d", gcd, err);
        check("gcd", 64'(gcd), 64'(r.g));
        check("err", 64'(err), 64'(r.e));
        check("busy_at_done", 64'(busy), 64'd0);
`ifdef GCD_ITER_COUNT_EN
        check("iters", 64'(iters), 64'(r.it));
`endif
      end
    end
  end

  task automatic issue(input int av, input int bv);
    @(posedge clk); #2;
    start = 1'b1; a = W'(av); b = W'(bv);
    @(posedge clk); #2;  // E0 just sampled start
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 500) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got no done expected done within 500 cycles", name);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_gcd"}, 64'(gcd), 64'd0);
    check({tag, "_mod_start"}, 64'(mod_start), 64'd0);
    check({tag, "_mod_dividend"}, 64'(mod_dividend), 64'd0);
    check({tag, "_mod_divisor"}, 64'(mod_divisor), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check_reset_vals("reset");
    rst = 1'b0;

    // 48,18: remainders 12, 6, 0
    push_op(48, 18); push_op(18, 12); push_op(12, 6); push_res(6, 1'b0, 3);
    issue(48, 18);
    check("busy_after_E0", 64'(busy), 64'd1);
    wait_done("j48_18");

    // 18,48: first op swaps the operands
    push_op(18, 48); push_op(48, 18); push_op(18, 12); push_op(12, 6); push_res(6, 1'b0, 4);
    issue(18, 48);
    wait_done("j18_48");

    // Zero-operand early exits: done in the cycle after E0, no mod_start
    push_res(35, 1'b0, 0);
    issue(0, 35);
    check("early_done_0_35", 64'(done), 64'd1);
    check("early_busy_0_35", 64'(busy), 64'd0);
    push_res(35, 1'b0, 0);
    issue(35, 0);
    check("early_done_35_0", 64'(done), 64'd1);
    push_res(0, 1'b0, 0);
    issue(0, 0);
    check("early_done_0_0", 64'(done), 64'd1);
    @(negedge clk);

    // Iteration limit: 89,55 aborts after the 4th remainder (8)
    push_op(89, 55); push_op(55, 34); push_op(34, 21); push_op(21, 13); push_res(13, 1'b1, 4);
    issue(89, 55);
    wait_done("j89_55");
    push_op(17, 5); push_op(5, 2); push_op(2, 1); push_res(1, 1'b0, 3);
    issue(17, 5);
    check("err_cleared_on_start", 64'(err), 64'd0);
    wait_done("j17_5");

    // Start while busy is ignored
    push_op(48, 18); push_op(18, 12); push_op(12, 6); push_res(6, 1'b0, 3);
    issue(48, 18);
    check("busy_before_ignored", 64'(busy), 64'd1);
    issue(100, 7);
    wait_done("j48_18_ignored");

    // Reset during WAIT: only the first op is seen, no done
    push_op(48, 18);
    issue(48, 18);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("midjob_rst");
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (3 * LAT) @(negedge clk);
    push_op(21, 14); push_op(14, 7); push_res(7, 1'b0, 2);
    issue(21, 14);
    wait_done("j21_14");

    repeat (3) @(negedge clk);
    check("ops_left", 64'(exp_op.size()), 64'd0);
    check("results_left", 64'(exp_res.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
